// File: rtl/breadboard_pkg.sv
// Shared definitions for the breadboard pmod blocks (button input stage and
// score shift-register output stage).
//   - tx_state_t   : state encoding of the score serializer
//   - SCORE_W      : default score word width (two 8-bit '595s)
//   - PMOD_CLK_DIV : default clk cycles per shift-clock half-period
//   - PMOD_*_IDX   : pmod pin indices used by the top-level pin assignment
package breadboard_pkg;

   localparam int unsigned SCORE_W      = 16;
   localparam int unsigned PMOD_CLK_DIV = 50;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_SETUP    = 2'd1;
   localparam logic [1:0] ST_SHIFT_HI = 2'd2;
   localparam logic [1:0] ST_LATCH    = 2'd3;

   typedef enum logic [1:0] {
      IDLE     = ST_IDLE,
      SETUP    = ST_SETUP,
      SHIFT_HI = ST_SHIFT_HI,
      LATCH    = ST_LATCH
   } tx_state_t;

   // Output side: 74HC595 chain
   localparam int unsigned PMOD_SER_IDX   = 0;
   localparam int unsigned PMOD_SRCLK_IDX = 1;
   localparam int unsigned PMOD_RCLK_IDX  = 2;
   localparam int unsigned PMOD_OE_N_IDX  = 3;
   // Input side: breadboard buttons
   localparam int unsigned PMOD_BTN_UP0_IDX = 4;
   localparam int unsigned PMOD_BTN_DN0_IDX = 5;
   localparam int unsigned PMOD_BTN_UP1_IDX = 6;
   localparam int unsigned PMOD_BTN_DN1_IDX = 7;

endpackage

// File: rtl/breadboard_score_tx.sv
// Score serializer for a 74HC595 chain on the breadboard pmod.
// A one-cycle load captures data; the word is shifted MSB first on
// pmod_ser/pmod_srclk, then pmod_rclk latches it and done pulses once.
// Ports:
//   clk, rst_n       : system clock, asynchronous active-low reset
//   load, data       : start request (IDLE only) and the word to send
//   busy, done       : frame in progress / one-cycle completion pulse
//   pmod_ser         : '595 SER
//   pmod_srclk       : '595 SRCLK (SER sampled on rising edge)
//   pmod_rclk        : '595 RCLK (storage latch)
//   pmod_oe_n        : '595 OE_n, held high until the first latch completes
module breadboard_score_tx
   import breadboard_pkg::*;
#(
   parameter int unsigned DATA_W  = SCORE_W,
   parameter int unsigned CLK_DIV = PMOD_CLK_DIV
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [DATA_W-1:0] data,
   output logic              busy,
   output logic              done,
   output logic              pmod_ser,
   output logic              pmod_srclk,
   output logic              pmod_rclk,
   output logic              pmod_oe_n
);

   localparam int unsigned DIV_W = $clog2(CLK_DIV) + 1;
   localparam int unsigned BIT_W = $clog2(DATA_W) + 1;
   localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

   tx_state_t         state;
   logic [DATA_W-1:0] shreg;
   logic [DIV_W-1:0]  div_cnt;
   logic [BIT_W-1:0]  bit_cnt;
   logic              div_last;

   assign div_last = (div_cnt == LAST_DIV);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         shreg      <= '0;
         div_cnt    <= '0;
         bit_cnt    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pmod_ser   <= 1'b0;
         pmod_srclk <= 1'b0;
         pmod_rclk  <= 1'b0;
         pmod_oe_n  <= 1'b1;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (load) begin
                  shreg    <= data;
                  pmod_ser <= data[DATA_W-1];
                  busy     <= 1'b1;
                  bit_cnt  <= '0;
                  div_cnt  <= '0;
                  state    <= SETUP;
               end
            end
            SETUP: begin
               if (div_last) begin
                  div_cnt    <= '0;
                  pmod_srclk <= 1'b1;
                  state      <= SHIFT_HI;
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end
            SHIFT_HI: begin
               if (div_last) begin
                  div_cnt    <= '0;
                  pmod_srclk <= 1'b0;
                  if (bit_cnt == LAST_BIT) begin
                     pmod_rclk <= 1'b1;
                     state     <= LATCH;
                  end else begin
                     // SER moves together with the srclk falling edge, giving
                     // a full SETUP phase of setup time before the next rise.
                     shreg    <= {shreg[DATA_W-2:0], 1'b0};
                     pmod_ser <= shreg[DATA_W-2];
                     bit_cnt  <= bit_cnt + BIT_W'(1);
                     state    <= SETUP;
                  end
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end
            LATCH: begin
               if (div_last) begin
                  div_cnt   <= '0;
                  pmod_rclk <= 1'b0;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  pmod_oe_n <= 1'b0;
                  state     <= IDLE;
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_breadboard_score_tx.sv
// Scoreboard bench for breadboard_score_tx: a small DUT (DATA_W=8, CLK_DIV=2)
// for the directed frame scenarios and a default-parameter DUT for timing.
module tb_breadboard_score_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        load_a, load_b;
   logic [7:0]  data_a;
   logic [15:0] data_b;
   logic busy_a, done_a, ser_a, srclk_a, rclk_a, oe_n_a;
   logic busy_b, done_b, ser_b, srclk_b, rclk_b, oe_n_b;

   breadboard_score_tx #(.DATA_W(8), .CLK_DIV(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .load(load_a), .data(data_a),
      .busy(busy_a), .done(done_a), .pmod_ser(ser_a), .pmod_srclk(srclk_a),
      .pmod_rclk(rclk_a), .pmod_oe_n(oe_n_a));

   breadboard_score_tx #(.DATA_W(16), .CLK_DIV(50)) dut_b (
      .clk(clk), .rst_n(rst_n), .load(load_b), .data(data_b),
      .busy(busy_b), .done(done_b), .pmod_ser(ser_b), .pmod_srclk(srclk_b),
      .pmod_rclk(rclk_b), .pmod_oe_n(oe_n_b));

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] word;
      int          busy_len;
   } exp_t;
   exp_t q_a[$];
   exp_t q_b[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // ---------------- monitor A ----------------
   logic [7:0] a_word;
   int a_rises, a_busy, a_rclk, a_unstable, a_dones, a_done_cyc;
   logic a_prev_srclk, a_prev_ser, a_prev_done;
   initial begin
      a_dones = 0; a_done_cyc = 0;
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         a_word = '0; a_rises = 0; a_busy = 0; a_rclk = 0; a_unstable = 0;
         a_prev_srclk = 1'b0; a_prev_ser = 1'b0; a_prev_done = 1'b0;
         q_a.delete();
      end else begin
         if (busy_a) a_busy++;
         if (rclk_a) a_rclk++;
         if (srclk_a && !a_prev_srclk) begin
            a_rises++;
            a_word = {a_word[6:0], ser_a};
            if (ser_a !== a_prev_ser) a_unstable++;
         end
         if (a_prev_done) check("a_done_one_cycle", {31'd0, done_a}, 32'd0);
         if (done_a) begin
            a_dones++;
            a_done_cyc = cyc;
            if (q_a.size() == 0) begin
               tests++; fails++;
               $display("FAIL a_unexpected_done: got done with empty scoreboard at cycle %0d", cyc);
            end else begin
               exp_t e;
               e = q_a.pop_front();
               check("a_word", {24'd0, a_word}, {16'd0, e.word});
               check("a_srclk_rises", a_rises, 8);
               check("a_busy_len", a_busy, e.busy_len);
               check("a_rclk_width", a_rclk, 2);
               check("a_oe_n_at_done", {31'd0, oe_n_a}, 32'd0);
               check("a_busy_in_done", {31'd0, busy_a}, 32'd0);
               check("a_ser_stable", a_unstable, 0);
            end
            a_word = '0; a_rises = 0; a_busy = 0; a_rclk = 0; a_unstable = 0;
         end
         a_prev_srclk = srclk_a;
         a_prev_ser   = ser_a;
         a_prev_done  = done_a;
      end
   end

   // ---------------- monitor B ----------------
   logic [15:0] b_word;
   int b_rises, b_busy, b_unstable, b_run, b_phases, b_bad_phase, b_dones;
   logic b_prev_srclk, b_prev_ser;
   initial b_dones = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         b_word = '0; b_rises = 0; b_busy = 0; b_unstable = 0; b_run = 0;
         b_phases = 0; b_bad_phase = 0; b_prev_srclk = 1'b0; b_prev_ser = 1'b0;
         q_b.delete();
      end else begin
         if (busy_b) begin
            b_busy++;
            if (srclk_b !== b_prev_srclk) begin
               b_phases++;
               if (b_run != 50) b_bad_phase++;
               b_run = 1;
            end else begin
               b_run++;
            end
         end else begin
            b_run = 0;
         end
         if (srclk_b && !b_prev_srclk) begin
            b_rises++;
            b_word = {b_word[14:0], ser_b};
            if (ser_b !== b_prev_ser) b_unstable++;
         end
         if (done_b) begin
            b_dones++;
            if (q_b.size() == 0) begin
               tests++; fails++;
               $display("FAIL b_unexpected_done: got done with empty scoreboard at cycle %0d", cyc);
            end else begin
               exp_t e;
               e = q_b.pop_front();
               check("b_word", {16'd0, b_word}, {16'd0, e.word});
               check("b_srclk_rises", b_rises, 16);
               check("b_busy_len", b_busy, e.busy_len);
               check("b_phase_count", b_phases, 32);
               check("b_bad_phases", b_bad_phase, 0);
               check("b_ser_stable", b_unstable, 0);
               check("b_oe_n_at_done", {31'd0, oe_n_b}, 32'd0);
            end
            b_word = '0; b_rises = 0; b_busy = 0; b_unstable = 0; b_phases = 0; b_bad_phase = 0;
         end
         b_prev_srclk = srclk_b;
         b_prev_ser   = ser_b;
      end
   end

   // ---------------- stimulus ----------------
   task automatic pulse_a(input logic [7:0] d);
      load_a = 1'b1; data_a = d;
      @(negedge clk);
      load_a = 1'b0; data_a = 8'h00;
   endtask

   task automatic wait_done_a(input string name, input int budget);
      int start, n;
      start = a_dones; n = 0;
      while (a_dones == start && n < budget) begin
         @(negedge clk); #1; n++;
      end
      if (a_dones == start) begin
         tests++; fails++;
         $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_busy"},  {31'd0, busy_a},  32'd0);
      check({name, "_done"},  {31'd0, done_a},  32'd0);
      check({name, "_ser"},   {31'd0, ser_a},   32'd0);
      check({name, "_srclk"}, {31'd0, srclk_a}, 32'd0);
      check({name, "_rclk"},  {31'd0, rclk_a},  32'd0);
      check({name, "_oe_n"},  {31'd0, oe_n_a},  32'd1);
   endtask

   initial begin
      int c1, n;
      rst_n = 1'b0; load_a = 1'b0; load_b = 1'b0; data_a = '0; data_b = '0;
      repeat (2) @(negedge clk);
      check_reset_outputs("rst_a");
      check("rst_b_oe_n", {31'd0, oe_n_b}, 32'd1);
      check("rst_b_busy", {31'd0, busy_b}, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Basic frame
      q_a.push_back('{word: 16'h00A5, busy_len: 34});
      pulse_a(8'hA5);
      wait_done_a("t1", 60);
      repeat (3) @(negedge clk);

      // Load during a frame is ignored
      q_a.push_back('{word: 16'h003C, busy_len: 34});
      pulse_a(8'h3C);
      repeat (4) @(negedge clk);
      pulse_a(8'h00);
      wait_done_a("t2", 60);
      repeat (3) @(negedge clk);

      // Back-to-back frames with load held high
      q_a.push_back('{word: 16'h00FF, busy_len: 34});
      q_a.push_back('{word: 16'h00FF, busy_len: 34});
      load_a = 1'b1; data_a = 8'hFF;
      wait_done_a("t3a", 60);
      c1 = a_done_cyc;
      @(negedge clk);
      load_a = 1'b0;
      check("t3_busy_after_done", {31'd0, busy_a}, 32'd1);
      wait_done_a("t3b", 60);
      check("t3_done_spacing", a_done_cyc - c1, 35);
      repeat (3) @(negedge clk);

      // Asynchronous reset mid-frame, after the 4th srclk rise
      load_a = 1'b1; data_a = 8'hFF;
      @(negedge clk);
      load_a = 1'b0;
      n = 0;
      while (a_rises < 4 && n < 60) begin
         @(negedge clk); #1; n++;
      end
      check("t4_reached_rise4", a_rises, 4);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("t4_async");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      q_a.push_back('{word: 16'h0081, busy_len: 34});
      pulse_a(8'h81);
      wait_done_a("t4", 60);
      repeat (3) @(negedge clk);

      // Default parameters
      q_b.push_back('{word: 16'h1203, busy_len: 1650});
      load_b = 1'b1; data_b = 16'h1203;
      @(negedge clk);
      load_b = 1'b0; data_b = 16'hFFFF;
      n = 0;
      while (b_dones == 0 && n < 2000) begin
         @(negedge clk); #1; n++;
      end
      if (b_dones == 0) begin
         tests++; fails++;
         $display("FAIL b_timeout: no done within 2000 cycles");
      end
      repeat (3) @(negedge clk);
      check("final_a_queue_empty", q_a.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
